// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the stream FIFO family.
//   ptr_width    : bits needed to index DEPTH storage entries
//   count_width  : bits needed to hold an occupancy of 0..DEPTH
//   params_legal : parameter sanity check used at elaboration by stream_fifo
// -----------------------------------------------------------------------------
package fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int unsigned depth,
                                        input int unsigned afull_th,
                                        input int unsigned aempty_th);
        return (depth >= 2) && (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th < depth);
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Pointer, occupancy, flag and sticky-error bookkeeping for stream_fifo.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              synchronous clear (wins over any handshake)
//   w_valid_i, r_ready_i producer offer / consumer accept
//   wr_en_o              storage write strobe (accepted push)
//   wr_ptr_o, rd_ptr_o   storage write / read indices
//   count_o              registered occupancy
//   w_ready_o, r_valid_o handshake readies derived from count
//   full_o, empty_o, almost_full_o, almost_empty_o  occupancy flags
//   overflow_o, underflow_o                         sticky error flags
// -----------------------------------------------------------------------------
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter  int unsigned DEPTH     = 3,
    parameter  int unsigned AFULL_TH  = DEPTH - 1,
    parameter  int unsigned AEMPTY_TH = 1,
    localparam int unsigned PW        = ptr_width(DEPTH),
    localparam int unsigned CW        = count_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          w_valid_i,
    input  logic          r_ready_i,
    output logic          wr_en_o,
    output logic [PW-1:0] wr_ptr_o,
    output logic [PW-1:0] rd_ptr_o,
    output logic [CW-1:0] count_o,
    output logic          w_ready_o,
    output logic          r_valid_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic          almost_empty_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          full, empty, push, pop;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A full FIFO refuses the write even if a pop frees a slot this cycle.
    assign push  = w_valid_i && !full;
    assign pop   = r_ready_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(pop);
            ovf_d   = ovf_q | (w_valid_i & full);
            udf_d   = udf_q | (r_ready_i & empty);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign wr_en_o        = push && !flush_i;
    assign wr_ptr_o       = wr_ptr_q;
    assign rd_ptr_o       = rd_ptr_q;
    assign count_o        = count_q;
    assign w_ready_o      = !full;
    assign r_valid_o      = !empty;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= CW'(AFULL_TH));
    assign almost_empty_o = (count_q <= CW'(AEMPTY_TH));
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// First-word-fall-through FIFO with valid/ready handshakes on both sides.
// Ports:
//   clk, reset (async active-low), flush (sync clear)
//   w_valid / w_ready / data_in     write side
//   r_valid / r_ready / data_out    read side (data_out = head entry)
//   fifo_full, fifo_empty, almost_full, almost_empty, count  occupancy
//   overflow, underflow             sticky errors, cleared by flush/reset
// -----------------------------------------------------------------------------
module stream_fifo
    import fifo_pkg::*;
#(
    parameter  int unsigned WIDTH     = 32,
    parameter  int unsigned DEPTH     = 3,
    parameter  int unsigned AFULL_TH  = DEPTH - 1,
    parameter  int unsigned AEMPTY_TH = 1,
    localparam int unsigned CW        = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = ptr_width(DEPTH);

    if (!params_legal(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
        $error("stream_fifo: illegal DEPTH/AFULL_TH/AEMPTY_TH combination");
    end

    logic             wr_en;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem_q [DEPTH];

    fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) u_ctrl (
        .clk_i          (clk),
        .rst_ni         (reset),
        .flush_i        (flush),
        .w_valid_i      (w_valid),
        .r_ready_i      (r_ready),
        .wr_en_o        (wr_en),
        .wr_ptr_o       (wr_ptr),
        .rd_ptr_o       (rd_ptr),
        .count_o        (count),
        .w_ready_o      (w_ready),
        .r_valid_o      (r_valid),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .overflow_o     (overflow),
        .underflow_o    (underflow)
    );

    // Storage is intentionally not reset; count gates visibility of stale words.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= data_in;
    end

    assign data_out = mem_q[rd_ptr];

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        flush3, wv3, rr3;
    logic [31:0] din3, dout3;
    logic        wrdy3, rv3, full3, empty3, af3, ae3, ovf3, udf3;
    logic [1:0]  cnt3;

    logic        flush5, wv5, rr5;
    logic [31:0] din5, dout5;
    logic        wrdy5, rv5, full5, empty5, af5, ae5, ovf5, udf5;
    logic [2:0]  cnt5;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q3[$];
    logic [31:0] q5[$];

    stream_fifo #(.WIDTH(32), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset(rst_n), .flush(flush3),
        .w_valid(wv3), .w_ready(wrdy3), .data_in(din3),
        .r_valid(rv3), .r_ready(rr3), .data_out(dout3),
        .fifo_full(full3), .fifo_empty(empty3),
        .almost_full(af3), .almost_empty(ae3), .count(cnt3),
        .overflow(ovf3), .underflow(udf3)
    );

    stream_fifo #(.WIDTH(32), .DEPTH(5)) u_dut5 (
        .clk(clk), .reset(rst_n), .flush(flush5),
        .w_valid(wv5), .w_ready(wrdy5), .data_in(din5),
        .r_valid(rv5), .r_ready(rr5), .data_out(dout5),
        .fifo_full(full5), .fifo_empty(empty5),
        .almost_full(af5), .almost_empty(ae5), .count(cnt5),
        .overflow(ovf5), .underflow(udf5)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic checkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: pop expected word on every read handshake.
    always @(negedge clk) begin
        if (rst_n && rv3 && rr3) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dout3_unexpected actual=%0h required=none", dout3);
            end else begin
                check("dout3", dout3, q3.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rv5 && rr5) begin
            if (q5.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dout5_unexpected actual=%0h required=none", dout5);
            end else begin
                check("dout5", dout5, q5.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        flush3 = 0; wv3 = 0; rr3 = 0; din3 = '0;
        flush5 = 0; wv5 = 0; rr5 = 0; din5 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Reset / idle state
        checkb("rst_empty", empty3, 1'b1);
        checkb("rst_rvalid", rv3, 1'b0);
        check ("rst_count", 32'(cnt3), 32'd0);
        checkb("rst_wready", wrdy3, 1'b1);
        checkb("rst_full", full3, 1'b0);
        checkb("rst_aempty", ae3, 1'b1);
        checkb("rst_afull", af3, 1'b0);
        checkb("rst_ovf", ovf3, 1'b0);
        checkb("rst_udf", udf3, 1'b0);
        checkb("rst_empty5", empty5, 1'b1);

        // Fill DEPTH=3 with 0,1,2
        wv3 = 1; din3 = 32'd0; q3.push_back(32'd0); step();
        check("fill_cnt1", 32'(cnt3), 32'd1);
        din3 = 32'd1; q3.push_back(32'd1); step();
        check ("fill_cnt2", 32'(cnt3), 32'd2);
        checkb("fill_afull2", af3, 1'b1);
        checkb("fill_aempty2", ae3, 1'b0);
        din3 = 32'd2; q3.push_back(32'd2); step();
        checkb("full_full", full3, 1'b1);
        checkb("full_wready", wrdy3, 1'b0);
        check ("full_cnt", 32'(cnt3), 32'd3);
        checkb("full_afull", af3, 1'b1);
        checkb("full_ovf_before", ovf3, 1'b0);
        din3 = 32'd3; step();
        checkb("ovf_set", ovf3, 1'b1);
        check ("ovf_cnt", 32'(cnt3), 32'd3);
        wv3 = 0;

        // Drain
        rr3 = 1; step();
        check("drain_cnt2", 32'(cnt3), 32'd2);
        step();
        check("drain_cnt1", 32'(cnt3), 32'd1);
        step();
        check ("drain_cnt0", 32'(cnt3), 32'd0);
        checkb("drain_empty", empty3, 1'b1);
        checkb("drain_rvalid", rv3, 1'b0);
        checkb("drain_udf_before", udf3, 1'b0);
        step();
        checkb("udf_set", udf3, 1'b1);
        checkb("ovf_sticky", ovf3, 1'b1);
        rr3 = 0;

        // Flush clears sticky flags
        flush3 = 1; step(); flush3 = 0;
        checkb("flush_ovf", ovf3, 1'b0);
        checkb("flush_udf", udf3, 1'b0);

        // Simultaneous push/pop at count 2
        wv3 = 1; din3 = 32'd10; q3.push_back(32'd10); step();
        din3 = 32'd11; q3.push_back(32'd11); step();
        check("pp_start_cnt", 32'(cnt3), 32'd2);
        rr3 = 1;
        for (int i = 0; i < 20; i++) begin
            din3 = 32'(100 + i); q3.push_back(32'(100 + i)); step();
            check("pp_cnt", 32'(cnt3), 32'd2);
        end
        rr3 = 0; din3 = 32'd200; q3.push_back(32'd200); step();
        check("pp_full_cnt", 32'(cnt3), 32'd3);
        din3 = 32'd300; rr3 = 1; step();
        check ("full_pp_cnt", 32'(cnt3), 32'd2);
        checkb("full_pp_wready", wrdy3, 1'b1);
        checkb("full_pp_ovf", ovf3, 1'b1);
        rr3 = 0;

        // Flush at count 2 with a concurrent write
        din3 = 32'hDEAD; flush3 = 1; q3.delete(); step();
        flush3 = 0; wv3 = 0;
        check ("fl_cnt", 32'(cnt3), 32'd0);
        checkb("fl_empty", empty3, 1'b1);
        checkb("fl_ovf", ovf3, 1'b0);
        checkb("fl_udf", udf3, 1'b0);
        wv3 = 1; din3 = 32'h55; q3.push_back(32'h55); step();
        wv3 = 0; rr3 = 1; step();
        rr3 = 0;
        checkb("post_fl_empty", empty3, 1'b1);

        // Reset dropped mid-stream
        wv3 = 1; din3 = 32'hA1; q3.push_back(32'hA1); step();
        din3 = 32'hA2; q3.push_back(32'hA2); step();
        din3 = 32'hA3;
        #2;
        rst_n = 1'b0;
        q3.delete();
        #1;
        check ("arst_cnt", 32'(cnt3), 32'd0);
        checkb("arst_empty", empty3, 1'b1);
        checkb("arst_rvalid", rv3, 1'b0);
        wv3 = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        check ("post_rst_cnt", 32'(cnt3), 32'd0);
        checkb("post_rst_rvalid", rv3, 1'b0);

        // DEPTH=5 wrap: 4 writes, 8 push+pop, drain 4
        wv5 = 1;
        for (int i = 0; i < 4; i++) begin
            din5 = 32'h500 + 32'(i); q5.push_back(32'h500 + 32'(i)); step();
        end
        check ("w5_cnt4", 32'(cnt5), 32'd4);
        checkb("w5_afull", af5, 1'b1);
        rr5 = 1;
        for (int i = 4; i < 12; i++) begin
            din5 = 32'h500 + 32'(i); q5.push_back(32'h500 + 32'(i)); step();
            check("w5_pp_cnt", 32'(cnt5), 32'd4);
        end
        wv5 = 0;
        repeat (4) step();
        rr5 = 0;
        check ("w5_end_cnt", 32'(cnt5), 32'd0);
        checkb("w5_end_empty", empty5, 1'b1);
        checkb("w5_udf", udf5, 1'b0);

        step();
        check("q3_drained", 32'(q3.size()), 32'd0);
        check("q5_drained", 32'(q5.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
